pipe_regfile: RTL and testbench

//  Parametrised register file for the pipelined MIPS datapath; replaces the fixed 32x32 2-read/1-write file.

---
 rtl/pipe_regfile_pkg.sv | 13 +
 rtl/pipe_regfile_if.sv | 27 ++
 rtl/pipe_regfile_scrub_fsm.sv | 54 +++++
 rtl/pipe_regfile.sv | 74 +++++++
 tb/tb_pipe_regfile.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_regfile_pkg.sv
// Shared constants and scrub FSM encoding for the pipelined register file.
// The ID and WB stages import the default widths from here.
package pipe_rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } scrub_state_t;

endpackage

// File: rtl/pipe_regfile_if.sv
// Register-file access bundle: WB write port, ID read ports, scrub control.
// The pipeline side is the master; the register file is the slave.
interface pipe_regfile_if #(
  parameter int DATA_W = pipe_rf_pkg::DEF_DATA_W,
  parameter int ADDR_W = pipe_rf_pkg::DEF_ADDR_W,
  parameter int NREAD  = 2
) ();

  logic                      we;
  logic [ADDR_W-1:0]         waddr;
  logic [DATA_W-1:0]         wdata;
  logic [NREAD*ADDR_W-1:0]   raddr;
  logic [NREAD*DATA_W-1:0]   rdata;
  logic                      clear_req;
  logic                      busy;

  modport master (
    output we, waddr, wdata, raddr, clear_req,
    input  rdata, busy
  );

  modport slave (
    input  we, waddr, wdata, raddr, clear_req,
    output rdata, busy
  );

endinterface

// File: rtl/pipe_regfile_scrub_fsm.sv
// Sequential scrub controller: zeroes one register-file entry per clock,
// started by reset or by a clear request; busy is registered.
module rf_scrub_fsm
  import pipe_rf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              scrub_we,
  output logic [ADDR_W-1:0] scrub_addr
);

  scrub_state_t      r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SCRUB;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear_req) begin
            r_state <= SCRUB;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SCRUB: begin
          // Terminal entry ends the pass; clear_req is ignored while scrubbing.
          if (r_cnt == '1) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          r_cnt <= r_cnt + 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign scrub_we   = r_busy;
  assign scrub_addr = r_cnt;

endmodule

// File: rtl/pipe_regfile.sv
// Parametrised multi-read register file with write-through bypass,
// hard-wired zero register and sequential scrub on reset/clear.
module pipe_regfile
  import pipe_rf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NREAD   = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic           clk,
  input  logic           rst,
  pipe_regfile_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_scrub_we;
  logic [ADDR_W-1:0] w_scrub_addr;
  logic              w_norm_we;
  logic              w_arr_we;
  logic [ADDR_W-1:0] w_arr_addr;
  logic [DATA_W-1:0] w_arr_data;

  rf_scrub_fsm #(
    .ADDR_W (ADDR_W)
  ) u_scrub (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (bus.clear_req),
    .busy       (w_busy),
    .scrub_we   (w_scrub_we),
    .scrub_addr (w_scrub_addr)
  );

  // Normal writes are excluded while busy, so the two sources never collide.
  assign w_norm_we  = bus.we && !w_busy && ((bus.waddr != '0) || (ZERO_R0 == 0));
  assign w_arr_we   = w_scrub_we || w_norm_we;
  assign w_arr_addr = w_scrub_we ? w_scrub_addr : bus.waddr;
  assign w_arr_data = w_scrub_we ? '0 : bus.wdata;

  always_ff @(posedge clk) begin
    if (w_arr_we) begin
      r_mem[w_arr_addr] <= w_arr_data;
    end
  end

  assign bus.busy = w_busy;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;

    assign w_ra = bus.raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_rd = r_mem[w_ra];
      if (w_busy) begin
        w_rd = '0;
      end else if ((ZERO_R0 != 0) && (w_ra == '0)) begin
        w_rd = '0;
      end else if ((BYPASS != 0) && bus.we && (w_ra == bus.waddr)) begin
        w_rd = bus.wdata;
      end
    end

    assign bus.rdata[k*DATA_W +: DATA_W] = w_rd;
  end

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed self-checking bench for pipe_regfile: default, no-bypass and
// narrow/4-read configurations driven side by side.
module tb_pipe_regfile;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_regfile_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bd ();
  pipe_regfile_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bn ();
  pipe_regfile_if #(.DATA_W(16), .ADDR_W(3), .NREAD(4)) bs ();

  pipe_regfile #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(1), .ZERO_R0(1)) u_dut (
    .clk (clk), .rst (rst), .bus (bd)
  );
  pipe_regfile #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(0), .ZERO_R0(1)) u_nob (
    .clk (clk), .rst (rst), .bus (bn)
  );
  pipe_regfile #(.DATA_W(16), .ADDR_W(3), .NREAD(4), .BYPASS(1), .ZERO_R0(1)) u_small (
    .clk (clk), .rst (rst), .bus (bs)
  );

  int checks = 0;
  int errors = 0;
  int nd, ns;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rdd(input int k);
    return bd.rdata[k*32 +: 32];
  endfunction

  function automatic logic [31:0] rdn(input int k);
    return bn.rdata[k*32 +: 32];
  endfunction

  function automatic logic [31:0] rds(input int k);
    return {16'h0, bs.rdata[k*16 +: 16]};
  endfunction

  // Counts busy cycles of the default and small instances over a fixed window.
  task automatic count_scrub(input string tag, output int n_d, output int n_s);
    n_d = 0;
    n_s = 0;
    for (int c = 0; c < 40; c++) begin
      if (bd.busy === 1'b1) begin
        n_d++;
        chk({tag, "_rd_during_busy"}, rdd(0) | rdd(1), 32'h0);
      end
      if (bs.busy === 1'b1) n_s++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    bd.we = 1'b0; bd.waddr = '0; bd.wdata = '0; bd.raddr = {5'd9, 5'd3}; bd.clear_req = 1'b0;
    bn.we = 1'b0; bn.waddr = '0; bn.wdata = '0; bn.raddr = '0; bn.clear_req = 1'b0;
    bs.we = 1'b0; bs.waddr = '0; bs.wdata = '0; bs.raddr = '0; bs.clear_req = 1'b0;

    // 1. reset scrub
    tick();
    chk("rst_busy", {31'h0, bd.busy}, 32'h1);
    chk("rst_rd0", rdd(0), 32'h0);
    chk("rst_rd1", rdd(1), 32'h0);
    tick();
    rst = 1'b0;
    count_scrub("t1", nd, ns);
    chk("t1_busy_cycles", nd, 32);
    chk("t6_small_scrub_cycles", ns, 8);
    for (int i = 0; i < 32; i++) begin
      bd.raddr = {5'(31 - i), 5'(i)};
      #1;
      chk("t1_entry_zero", rdd(0) | rdd(1), 32'h0);
    end

    // 2. write then read
    bd.raddr = {5'd1, 5'd2};
    bd.we = 1'b1; bd.waddr = 5'd5; bd.wdata = 32'hDEADBEEF;
    tick();
    bd.we = 1'b0; bd.raddr = {5'd1, 5'd5};
    #1;
    chk("t2_read_back", rdd(0), 32'hDEADBEEF);
    chk("t2_other_port", rdd(1), 32'h0);

    // 3. bypass vs no bypass
    bd.we = 1'b1; bd.waddr = 5'd7; bd.wdata = 32'h12345678; bd.raddr = {5'd7, 5'd7};
    bn.we = 1'b1; bn.waddr = 5'd7; bn.wdata = 32'h12345678; bn.raddr = {5'd7, 5'd7};
    #1;
    chk("t3_byp_rd0", rdd(0), 32'h12345678);
    chk("t3_byp_rd1", rdd(1), 32'h12345678);
    chk("t3_nobyp_rd0", rdn(0), 32'h0);
    chk("t3_nobyp_rd1", rdn(1), 32'h0);
    tick();
    bd.we = 1'b0; bn.we = 1'b0;
    #1;
    chk("t3_nobyp_after", rdn(0), 32'h12345678);
    chk("t3_byp_after", rdd(1), 32'h12345678);

    // 4. zero register
    bd.we = 1'b1; bd.waddr = 5'd0; bd.wdata = 32'hFFFFFFFF; bd.raddr = {5'd0, 5'd0};
    #1;
    chk("t4_r0_same_cycle", rdd(0), 32'h0);
    tick();
    bd.we = 1'b0;
    #1;
    chk("t4_r0_after", rdd(0), 32'h0);

    // clear during scrub is ignored; write during scrub is dropped
    bd.clear_req = 1'b1;
    tick();
    bd.clear_req = 1'b0;
    #1;
    chk("clr_busy_next", {31'h0, bd.busy}, 32'h1);
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      if (bd.busy === 1'b1) nd++;
      bd.clear_req = (c == 20);
      bd.we = (c == 25);
      bd.waddr = 5'd5; bd.wdata = 32'hCAFEF00D; bd.raddr = {5'd5, 5'd5};
      #1;
      if (c == 25) chk("clr_busy_over_bypass", rdd(0), 32'h0);
      tick();
    end
    bd.we = 1'b0; bd.clear_req = 1'b0;
    chk("clr_ignored_cycles", nd, 32);
    #1;
    chk("clr_write_dropped", rdd(0), 32'h0);
    bd.raddr = {5'd7, 5'd1};
    #1;
    chk("clr_entry7_zero", rdd(1), 32'h0);

    // 5. mid-scrub write and reset
    bd.clear_req = 1'b1;
    tick();
    bd.clear_req = 1'b0;
    #1;
    chk("t5_busy", {31'h0, bd.busy}, 32'h1);
    tick();
    bd.we = 1'b1; bd.waddr = 5'd3; bd.wdata = 32'hA5A5A5A5; bd.raddr = {5'd3, 5'd3};
    #1;
    chk("t5_busy_masks_bypass", rdd(0), 32'h0);
    tick();
    bd.we = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_scrub("t5", nd, ns);
    chk("t5_restart_cycles", nd, 32);
    chk("t5_small_cycles", ns, 8);
    bd.raddr = {5'd3, 5'd3};
    #1;
    chk("t5_entry3_zero", rdd(0), 32'h0);

    // 6. narrow, four-port instance
    for (int i = 1; i < 8; i++) begin
      bs.we = 1'b1; bs.waddr = 3'(i); bs.wdata = 16'(17 * i);
      tick();
    end
    bs.we = 1'b0;
    bs.raddr = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    for (int k = 0; k < 4; k++) chk("t6_port_pat1", rds(k), 32'(17 * (k + 1)));
    bs.raddr = {3'd0, 3'd5, 3'd6, 3'd7};
    #1;
    chk("t6_p0_e7", rds(0), 32'h0077);
    chk("t6_p1_e6", rds(1), 32'h0066);
    chk("t6_p2_e5", rds(2), 32'h0055);
    chk("t6_p3_e0", rds(3), 32'h0000);
    bs.we = 1'b1; bs.waddr = 3'd2; bs.wdata = 16'hBEEF; bs.raddr = {3'd2, 3'd2, 3'd2, 3'd2};
    #1;
    for (int k = 0; k < 4; k++) chk("t6_bypass_all", rds(k), 32'h0000BEEF);
    tick();
    bs.we = 1'b0;
    #1;
    chk("t6_written", rds(3), 32'h0000BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
